// File: rtl/demux_pkg.sv
// demux_pkg: shared FSM state type and round-robin search helper for the dispatcher
package demux_pkg;
    typedef enum logic {IDLE, XFER} state_t;
    localparam int MAX_N = 16;
    function automatic logic [3:0] next_rr(input logic [3:0] ptr, input logic [MAX_N-1:0] mask, input int n);
        logic [3:0] res;
        int idx;
        res = ptr;
        // scan downward so the closest enabled index at or after ptr wins
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx -= n;
                if (mask[idx]) res = 4'(idx);
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker returning first enabled index at or after ptr
module rr_pick
    import demux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_mask,
    input  logic [SW-1:0] i_ptr,
    output logic [SW-1:0] o_grant,
    output logic          o_found
);
    logic [MAX_N-1:0] w_mask;
    logic [3:0]       w_ptr;
    assign w_mask  = MAX_N'(i_mask);
    assign w_ptr   = 4'(i_ptr);
    assign o_grant = SW'(next_rr(w_ptr, w_mask, N));
    assign o_found = |i_mask;
endmodule

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: per-packet round-robin channel grant driving a 1xN demux
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int SEL_WIDTH = $clog2(N),
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_last,
    input  logic [N-1:0]         chan_en,
    output logic [N-1:0]         m_valid,
    input  logic [N-1:0]         m_ready,
    output logic [DW-1:0]        m_data,
    output logic                 m_last,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 busy,
    output logic [CNT_W-1:0]     pkt_count
);
    state_t               r_state, w_next;
    logic [SEL_WIDTH-1:0] r_sel, r_ptr, w_grant;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_found, w_busy, w_done;

    rr_pick #(.N(N), .SW(SEL_WIDTH)) u_pick (
        .i_mask (chan_en),
        .i_ptr  (r_ptr),
        .o_grant(w_grant),
        .o_found(w_found)
    );

    assign w_busy    = r_state == XFER;
    assign s_ready   = w_busy && m_ready[r_sel];
    assign m_valid   = (w_busy && s_valid) ? N'(1) << r_sel : '0;
    assign m_data    = s_data;
    assign m_last    = s_last && |m_valid;
    assign sel       = r_sel;
    assign busy      = w_busy;
    assign pkt_count = r_cnt;
    assign w_done    = s_valid && s_ready && s_last;

    always_comb begin
        w_next = (r_state == IDLE) ? ((s_valid && w_found) ? XFER : IDLE) : (w_done ? IDLE : XFER);
    end

    // explicit wrap keeps the pointer below N when N is not a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == XFER) r_sel <= w_grant;
            if (w_done) begin
                r_ptr <= (r_sel == SEL_WIDTH'(N - 1)) ? '0 : r_sel + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(m_valid));
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb_demux_rr_dispatcher: table-driven directed check of the round-robin dispatcher
module tb_demux_rr_dispatcher;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s_valid, s_ready, s_last, m_last, busy;
    logic [7:0]  s_data, m_data;
    logic [3:0]  chan_en, m_valid, m_ready;
    logic [1:0]  sel;
    logic [15:0] pkt_count;

    logic        b_s_valid, b_s_ready, b_s_last, b_m_last, b_busy;
    logic [7:0]  b_s_data, b_m_data;
    logic [2:0]  b_chan_en, b_m_valid, b_m_ready;
    logic [1:0]  b_sel;
    logic [15:0] b_pkt_count;

    demux_rr_dispatcher #(.N(4), .DW(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .chan_en(chan_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .sel(sel), .busy(busy), .pkt_count(pkt_count)
    );

    demux_rr_dispatcher #(.N(3), .DW(8), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .s_last(b_s_last), .chan_en(b_chan_en), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_data(b_m_data), .m_last(b_m_last), .sel(b_sel), .busy(b_busy), .pkt_count(b_pkt_count)
    );

    typedef struct packed {
        logic        sv;
        logic [7:0]  d;
        logic        sl;
        logic [3:0]  en;
        logic [3:0]  mr;
        logic        sr;
        logic [3:0]  mv;
        logic [1:0]  sel;
        logic        bsy;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(input logic sv, input logic [7:0] d, input logic sl, input logic [3:0] en,
                                input logic [3:0] mr, input logic sr, input logic [3:0] mv,
                                input logic [1:0] sl_exp, input logic bsy, input logic [15:0] cnt);
        tbl.push_back('{sv, d, sl, en, mr, sr, mv, sl_exp, bsy, cnt});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int prev, cnt, s;
        int seq2[5] = '{1, 3, 1, 3, 1};
        prev = 0;
        cnt = 0;
        // four 3-beat packets, all channels enabled
        for (int p = 0; p < 4; p++) begin
            add(1, 8'(p * 16), 0, 4'hF, 4'hF, 0, 4'h0, 2'(prev), 0, 16'(cnt));
            for (int b = 0; b < 3; b++)
                add(1, 8'(p * 16 + b), b == 2, 4'hF, 4'hF, 1, 4'(1 << p), 2'(p), 1, 16'(cnt));
            prev = p;
            cnt++;
        end
        // sparse mask 1010: single-beat packets alternate 1,3
        for (int k = 0; k < 5; k++) begin
            s = seq2[k];
            add(1, 8'(8'h40 + k), 1, 4'b1010, 4'hF, 0, 4'h0, 2'(prev), 0, 16'(cnt));
            add(1, 8'(8'h40 + k), 1, 4'b1010, 4'hF, 1, 4'(1 << s), 2'(s), 1, 16'(cnt));
            prev = s;
            cnt++;
        end
        // channel 2 stalls for 5 cycles mid-packet
        add(1, 8'hA0, 0, 4'hF, 4'hF, 0, 4'h0, 2'd1, 0, 16'd9);
        add(1, 8'hA0, 0, 4'hF, 4'hF, 1, 4'b0100, 2'd2, 1, 16'd9);
        for (int k = 0; k < 5; k++)
            add(1, 8'hA1, 0, 4'hF, 4'b1011, 0, 4'b0100, 2'd2, 1, 16'd9);
        add(1, 8'hA1, 0, 4'hF, 4'hF, 1, 4'b0100, 2'd2, 1, 16'd9);
        add(1, 8'hA2, 1, 4'hF, 4'hF, 1, 4'b0100, 2'd2, 1, 16'd9);
        // no channel enabled: beat must wait, then channel 2 alone
        for (int k = 0; k < 10; k++)
            add(1, 8'hB0, 1, 4'h0, 4'hF, 0, 4'h0, 2'd2, 0, 16'd10);
        add(1, 8'hB0, 1, 4'b0100, 4'hF, 0, 4'h0, 2'd2, 0, 16'd10);
        add(1, 8'hB0, 1, 4'b0100, 4'hF, 1, 4'b0100, 2'd2, 1, 16'd10);
        // clearing the granted channel's enable mid-packet must not abort it
        add(1, 8'hC0, 0, 4'hF, 4'hF, 0, 4'h0, 2'd2, 0, 16'd11);
        add(1, 8'hC0, 0, 4'hF, 4'hF, 1, 4'b1000, 2'd3, 1, 16'd11);
        add(1, 8'hC1, 0, 4'b0111, 4'hF, 1, 4'b1000, 2'd3, 1, 16'd11);
        add(1, 8'hC2, 1, 4'b0111, 4'hF, 1, 4'b1000, 2'd3, 1, 16'd11);
        add(0, 8'h00, 0, 4'hF, 4'hF, 0, 4'h0, 2'd3, 0, 16'd12);

        rst_n = 1'b0;
        s_valid = 0; s_data = 0; s_last = 0; chan_en = 4'hF; m_ready = 4'hF;
        b_s_valid = 0; b_s_data = 0; b_s_last = 0; b_chan_en = 3'b111; b_m_ready = 3'b111;
        #1;
        chk("rst.s_ready", 32'(s_ready), 0);
        chk("rst.m_valid", 32'(m_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst.sel", 32'(sel), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.pkt_count", 32'(pkt_count), 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            s_valid = tbl[i].sv; s_data = tbl[i].d; s_last = tbl[i].sl;
            chan_en = tbl[i].en; m_ready = tbl[i].mr;
            #1;
            chk($sformatf("v%0d.s_ready", i), 32'(s_ready), 32'(tbl[i].sr));
            chk($sformatf("v%0d.m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            chk($sformatf("v%0d.sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("v%0d.pkt_count", i), 32'(pkt_count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d.m_data", i), 32'(m_data), 32'(tbl[i].d));
            chk($sformatf("v%0d.m_last", i), 32'(m_last), 32'(tbl[i].sl && |tbl[i].mv));
        end

        // reset in the middle of a packet on channel 2
        @(negedge clk);
        s_valid = 1; s_data = 8'h77; s_last = 0; chan_en = 4'b0100; m_ready = 4'hF;
        #1 chk("mid.idle_busy", 32'(busy), 0);
        @(negedge clk);
        #1 chk("mid.m_valid", 32'(m_valid), 32'b0100);
        @(negedge clk);
        s_data = 8'h78;
        #1 chk("mid.busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.m_valid", 32'(m_valid), 0);
        chk("arst.s_ready", 32'(s_ready), 0);
        chk("arst.sel", 32'(sel), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.pkt_count", 32'(pkt_count), 0);
        @(negedge clk);
        rst_n = 1'b1; s_valid = 1; s_data = 8'h99; s_last = 1; chan_en = 4'hF;
        #1 chk("post.busy", 32'(busy), 0);
        @(negedge clk);
        #1;
        chk("post.sel", 32'(sel), 0);
        chk("post.m_valid", 32'(m_valid), 32'b0001);
        chk("post.s_ready", 32'(s_ready), 1);
        @(negedge clk);
        s_valid = 0;
        #1 chk("post.pkt_count", 32'(pkt_count), 1);

        // N=3: wrap 2 -> 0 without ever reaching index 3
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            b_s_valid = 1; b_s_last = 1; b_s_data = 8'(k);
            #1 chk($sformatf("n3.%0d.busy", k), 32'(b_busy), 0);
            @(negedge clk);
            #1;
            chk($sformatf("n3.%0d.sel", k), 32'(b_sel), 32'(k % 3));
            chk($sformatf("n3.%0d.m_valid", k), 32'(b_m_valid), 32'(1 << (k % 3)));
            chk($sformatf("n3.%0d.s_ready", k), 32'(b_s_ready), 1);
        end
        @(negedge clk);
        b_s_valid = 0;
        #1 chk("n3.pkt_count", 32'(b_pkt_count), 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
Packet-level controller that sequences a 1xN demux so one input stream can feed N downstream consumers. It picks a destination channel per packet by round-robin over enabled channels, and holds the select stable for the whole packet. It carries valid/ready handshakes on both sides and routes s_data to the granted channel. It sits between a single producer and N consumer lanes; its sel output drives the demux select, and its m_valid vector is the demuxed valid.

Parameters:
N, 4, number of output channels (2..16; need not be a power of two)
DW, 8, data width in bits
SEL_WIDTH, $clog2(N), width of the channel select
CNT_W, 16, width of the packet counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  upstream beat valid
s_ready  output  1  upstream beat accepted when s_valid && s_ready
s_data  input  DW  upstream beat data
s_last  input  1  final beat of packet
chan_en  input  N  per-channel enable mask; sampled only at arbitration
m_valid  output  N  one-hot (or zero) per-channel valid
m_ready  input  N  per-channel ready
m_data  output  DW  data broadcast to all channels (= s_data)
m_last  output  1  = s_last, qualified by m_valid
sel  output  SEL_WIDTH  currently granted channel index
busy  output  1  high while a packet is in flight (XFER state)
pkt_count  output  CNT_W  completed packets since reset, wraps at 2^CNT_W

Behaviour:
- Reset (async, rst_n low): state=IDLE, sel=0, rr_ptr=0, pkt_count=0, busy=0. Outputs s_ready=0 and m_valid='0 immediately.
- FSM has 2 states: IDLE and XFER.
- IDLE: s_ready=0, m_valid='0, busy=0.
  - If s_valid && |chan_en: grant the first enabled channel scanning rr_ptr, rr_ptr+1, ... and wrapping N-1 -> 0. Register it into sel and go to XFER next cycle.
  - If chan_en==0: stay in IDLE, s_ready held 0, and do not drop the beat.
- XFER: busy=1. m_valid[sel]=s_valid and all other bits 0. s_ready=m_ready[sel]. m_data=s_data and m_last=s_last, combinational pass-through with zero added latency.
  - Beat = s_valid && s_ready.
  - Beat with s_last=1: go to IDLE next cycle, rr_ptr <= (sel==N-1) ? 0 : sel+1, pkt_count++.
- Latency: first beat of a packet transfers no earlier than 1 cycle after s_valid is seen in IDLE. There is a 1-cycle bubble between back-to-back packets.
- Grant is stable for the whole packet. Changes to chan_en or m_ready on other channels mid-packet are ignored; deasserting chan_en[sel] mid-packet does not abort the packet.
- Backpressure: m_ready[sel]=0 stalls upstream via s_ready=0. s_data must be held by the producer (standard valid/ready rules).
- sel is never >= N. The wrap logic is explicit for non-power-of-two N.
- Single-beat packet (s_last on first beat): IDLE -> XFER -> IDLE, 1 beat, counter +1.
- Reset asserted mid-packet: immediate return to IDLE. The partial packet is abandoned with no flush, and pkt_count is not incremented.
- m_valid is always one-hot or zero. Assertion: $onehot0(m_valid).

Decomposition:
- Shared package demux_pkg holds the state enum typedef (IDLE, XFER) and a function next_rr(ptr, mask) returning the first enabled index at or after ptr with wrap.
- One natural sub-module, rr_pick: combinational round-robin priority picker taking N, mask, and ptr, and returning a grant index plus a found flag. It is reusable by other arbiters.
- The existing demux_1xN can be instantiated for m_valid (din=s_valid & busy, sel=sel) rather than re-coding the decode.

Test Plan:
- Reset then N=4, chan_en=4'b1111, all m_ready=1, four 3-beat packets -> grants sel=0,1,2,3 in order, each packet's 3 beats appear only on its channel, pkt_count=4.
- chan_en=4'b1010, rr_ptr=0, five 1-beat packets -> sel sequence 1,3,1,3,1; m_valid never sets bits 0 or 2.
- Packet to sel=2 with m_ready[2] low for 5 cycles mid-packet -> s_ready=0 for exactly those 5 cycles, no beat lost or duplicated, data order preserved.
- chan_en=0 with s_valid=1 for 10 cycles, then chan_en=4'b0100 -> s_ready=0 and busy=0 throughout; grant sel=2 one cycle after the enable, first beat accepted.
- Clear chan_en[sel] mid-packet, then assert rst_n=0 mid-packet on a later packet -> first packet completes on its original channel; after the reset, m_valid=0, sel=0, pkt_count=0, and the next packet grants channel 0.
- N=3 (non-power-of-two), all enabled, 7 packets -> sel 0,1,2,0,1,2,0; sel never equals 3.
